ysyx_040978_divider: RTL

- Iterative radix-2 non-restoring divider for the RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW instructions.
- It is the division counterpart of the Booth radix-4 multiplier datapath and sits beside the multiplier in the EXU.
- It accepts one operation per valid/ready handshake, iterates one quotient bit per cycle, and returns quotient and remainder on a second valid/ready handshake.
- The RISC-V divide-by-zero and signed-overflow results are produced without iterating.

---
 rtl/ysyx_040978_divider.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ysyx_040978_divider.sv
// Iterative radix-2 non-restoring divider for RV64M DIV/DIVU/REM/REMU and their W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow finish without iterating.
module ysyx_040978_divider #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);
  localparam int PW   = XLEN + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_DBL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_WORD = {{HALF{1'b1}}, 1'b1, {(HALF-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   prem;
  logic [XLEN-1:0] quo_acc;
  logic [XLEN-1:0] dsor;
  logic            word_q;
  logic            sign_q;
  logic            sign_r;

  function automatic logic [XLEN-1:0] sext_word(input logic [HALF-1:0] x);
    return {{HALF{x[HALF-1]}}, x};
  endfunction

  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b;
  logic [XLEN-1:0] sp_quo, sp_rem;
  logic            sa, sb, div_zero, overflow;

  always_comb begin
    a_ext = dividend;
    b_ext = divisor;
    if (div_word) begin
      a_ext = div_signed ? sext_word(dividend[HALF-1:0]) : {{HALF{1'b0}}, dividend[HALF-1:0]};
      b_ext = div_signed ? sext_word(divisor[HALF-1:0])  : {{HALF{1'b0}}, divisor[HALF-1:0]};
    end
    sa       = div_signed & a_ext[XLEN-1];
    sb       = div_signed & b_ext[XLEN-1];
    abs_a    = sa ? -a_ext : a_ext;
    abs_b    = sb ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    overflow = div_signed && (a_ext == (div_word ? MIN_WORD : MIN_DBL)) && (b_ext == '1);
    sp_quo   = div_zero ? '1 : a_ext;
    sp_rem   = div_zero ? (div_word ? sext_word(dividend[HALF-1:0]) : dividend) : '0;
  end

  // The partial remainder carries two extra bits so 2P +/- D never overflows for
  // a full 64-bit unsigned divisor.
  logic [PW-1:0] shifted, step_rem;
  logic          q_bit;

  always_comb begin
    shifted  = {prem[PW-2:0], quo_acc[XLEN-1]};
    step_rem = prem[PW-1] ? shifted + {2'b00, dsor} : shifted - {2'b00, dsor};
    q_bit    = ~step_rem[PW-1];
  end

  logic [XLEN-1:0] r_mag, q_sgn, r_sgn, q_final, r_final;

  always_comb begin
    r_mag   = prem[XLEN-1:0] + (prem[PW-1] ? dsor : '0);
    q_sgn   = sign_q ? -quo_acc : quo_acc;
    r_sgn   = sign_r ? -r_mag : r_mag;
    q_final = word_q ? sext_word(q_sgn[HALF-1:0]) : q_sgn;
    r_final = word_q ? sext_word(r_sgn[HALF-1:0]) : r_sgn;
  end

  assign div_ready = (state == IDLE);
  assign out_valid = (state == DONE);

  // Word operands are left-aligned so the same MSB-first shift works for both widths.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      prem      <= '0;
      quo_acc   <= '0;
      dsor      <= '0;
      word_q    <= 1'b0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid) begin
            word_q <= div_word;
            sign_q <= sa ^ sb;
            sign_r <= sa;
            if (div_zero || overflow) begin
              quotient  <= div_word ? sext_word(sp_quo[HALF-1:0]) : sp_quo;
              remainder <= sp_rem;
              state     <= DONE;
            end else begin
              prem    <= '0;
              quo_acc <= div_word ? {abs_a[HALF-1:0], {HALF{1'b0}}} : abs_a;
              dsor    <= abs_b;
              cnt     <= div_word ? CW'(HALF - 1) : CW'(XLEN - 1);
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          prem    <= step_rem;
          quo_acc <= {quo_acc[XLEN-2:0], q_bit};
          cnt     <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quotient  <= q_final;
          remainder <= r_final;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
